bcd_to_binary: RTL and testbench
================================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  conversion request, sampled only in IDLE.
REQ-004 SHALL have ports: d3, d2, d1, d0  input  4 each  BCD digits (thousands, hundreds, tens, units).
REQ-005 SHALL have port: binary_out  output  14  registered binary result.
REQ-006 SHALL have port: done  output  1  one-cycle pulse, binary_out valid and updated.
REQ-007 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port: err  output  1  invalid-digit flag, meaningful only with BCD_DIGIT_CHECK_EN.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-010 IDLE: on an edge with start=1, SHALL latch {d3,d2,d1,d0} into a 16-bit BCD shift register, clear the 14-bit binary register and a 4-bit counter, and go to SHIFT; with start=0, SHALL stay in IDLE.
REQ-011 SHIFT: each edge SHALL shift {bcd,bin} (30 bits) right by one, with the bcd LSB entering the bin MSB, then subtract 3 from every BCD nibble whose post-shift value is >= 8.
REQ-012 SHIFT SHALL run exactly 14 edges (counter 0..13); at counter=13 it SHALL go to DONE.
REQ-013 DONE: in one edge, SHALL load binary_out with bin, set done=1, and go to IDLE.
REQ-014 Latency: if start is sampled at edge E0, done SHALL be high from edge E0+15 to E0+16, exactly one cycle.
REQ-015 binary_out SHALL equal 1000*d3+100*d2+10*d1+d0 for valid digits (range 0..9999).
REQ-016 binary_out SHALL hold its value between conversions, changing only in DONE or on reset.
REQ-017 busy SHALL be registered high from E0 until E0+15, and low in the same cycle that done is high.
REQ-018 SHALL ignore start while busy=1; input digits SHALL be ignored except at the sampling edge.
REQ-019 A start sampled in the cycle where done=1 (FSM in IDLE) SHALL be accepted, so back-to-back conversions run every 16 cycles.

Reset
REQ-020 When n_rst=0, SHALL immediately force: state IDLE, binary_out=0, done=0, busy=0, err=0, counter=0, internal registers=0.
REQ-021 Reset asserted mid-conversion SHALL abort it: no done pulse, and binary_out SHALL read 0 after reset.
REQ-022 After n_rst deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-023 Macro BCD_DIGIT_CHECK_EN defined: at the sampling edge, SHALL check each latched digit for a value >9.
REQ-024 With BCD_DIGIT_CHECK_EN, if any digit is >9, the DONE edge SHALL set err=1 and binary_out=0, with done timing unchanged.
REQ-025 With BCD_DIGIT_CHECK_EN, err SHALL hold until the next DONE edge or reset; a valid conversion SHALL clear it.
REQ-026 Without BCD_DIGIT_CHECK_EN, no check logic SHALL exist and err SHALL be tied to 0.
REQ-027 Without BCD_DIGIT_CHECK_EN, binary_out for invalid digits SHALL be whatever REQ-011 produces and is not checked.

Verification
REQ-028 Digits 0,0,0,0 with start -> done at E0+15, binary_out=0x0000, err=0.
REQ-029 Digits 9,9,9,9 -> binary_out=9999 (0x270F); digits 1,2,3,4 -> binary_out=1234 (0x04D2).
REQ-030 Start pulsed at E0+5 with different digits during a 1,2,3,4 conversion -> ignored; result 1234, a single done pulse.
REQ-031 n_rst low at E0+7 -> no done pulse; binary_out=0, busy=0; a next start converts 0,0,5,7 to 57.
REQ-032 Start held high continuously with 0,8,0,0 -> done pulses every 16 cycles, each with binary_out=800.
REQ-033 With BCD_DIGIT_CHECK_EN, digits 0,0,0xA,0 -> err=1, binary_out=0 at done; a following 0,0,1,0 conversion -> err=0, binary_out=10.

Source files
------------

// File: rtl/bcd_to_binary_if.sv
// BCD-to-binary converter handshake bundle.
// Master requests a conversion, slave returns the result.
interface bcd_to_binary_if;
    logic        start;
    logic [3:0]  d3;
    logic [3:0]  d2;
    logic [3:0]  d1;
    logic [3:0]  d0;
    logic [13:0] binary_out;
    logic        done;
    logic        busy;
    logic        err;

    modport master (
        output start,
        output d3,
        output d2,
        output d1,
        output d0,
        input  binary_out,
        input  done,
        input  busy,
        input  err
    );

    modport slave (
        input  start,
        input  d3,
        input  d2,
        input  d1,
        input  d0,
        output binary_out,
        output done,
        output busy,
        output err
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Four-digit BCD to 14-bit binary, reverse double-dabble, 16 cycles.
// Optional BCD_DIGIT_CHECK_EN flags digits above 9 through err.
module bcd_to_binary (
    input  logic            clk,
    input  logic            n_rst,
    bcd_to_binary_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] bcd_q;
    logic [13:0] bin_q;
    logic [3:0]  cnt_q;
    logic [29:0] sh_raw;
    logic [29:0] sh_next;

`ifdef BCD_DIGIT_CHECK_EN
    logic        bad_q;
    logic        bad_in;

    // Any latched digit above 9 poisons this conversion.
    always_comb begin
        bad_in = (bus.d3 > 4'd9) | (bus.d2 > 4'd9) |
                 (bus.d1 > 4'd9) | (bus.d0 > 4'd9);
    end
`else
    assign bus.err = 1'b0;
`endif

    // One shift step: halve the whole word, then fix up BCD nibbles.
    always_comb begin
        sh_raw  = {bcd_q, bin_q} >> 1;
        sh_next = sh_raw;
        for (int k = 0; k < 4; k++) begin
            if (sh_raw[14 + 4*k +: 4] >= 4'd8) begin
                sh_next[14 + 4*k +: 4] = sh_raw[14 + 4*k +: 4] - 4'd3;
            end
        end
    end

    // Control FSM with registered result, done pulse and busy flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= IDLE;
            bcd_q          <= '0;
            bin_q          <= '0;
            cnt_q          <= '0;
            bus.binary_out <= '0;
            bus.done       <= 1'b0;
            bus.busy       <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            bad_q          <= 1'b0;
            bus.err        <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        bcd_q    <= {bus.d3, bus.d2, bus.d1, bus.d0};
                        bin_q    <= '0;
                        cnt_q    <= '0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
`ifdef BCD_DIGIT_CHECK_EN
                        bad_q    <= bad_in;
`endif
                    end
                end
                SHIFT: begin
                    bcd_q <= sh_next[29:14];
                    bin_q <= sh_next[13:0];
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd13) begin
                        state <= DONE;
                    end
                end
                DONE: begin
`ifdef BCD_DIGIT_CHECK_EN
                    bus.binary_out <= bad_q ? 14'd0 : bin_q;
                    bus.err        <= bad_q;
`else
                    bus.binary_out <= bin_q;
`endif
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary.
// Driver queues expected results; monitor checks each done pulse.
module tb_bcd_to_binary;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    bcd_to_binary_if bus ();

    bcd_to_binary dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct {
        logic [13:0] val;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // Edge counter: value after edge N is N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (n_rst && bus.done) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 expected none (cycle %0d)",
                         cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("value", int'(bus.binary_out), int'(e.val));
                check("err", int'(bus.err), int'(e.err));
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", int'(bus.busy), 0);
            end
        end
    end

    task automatic push_exp(input int v, input bit er, input int c);
        exp_t e;
        e.val = v[13:0];
        e.err = er;
        e.cyc = c;
        q.push_back(e);
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        bus.d3 = a;
        bus.d2 = b;
        bus.d1 = c;
        bus.d0 = d;
    endtask

    // Issue one conversion once the converter is idle.
    task automatic go(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d,
                      input int v, input bit er);
        int k;
        k = 0;
        @(negedge clk);
        while (bus.busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_timeout: got busy=1 expected 0 (cycle %0d)", cyc);
        end
        set_digits(a, b, c, d);
        bus.start = 1'b1;
        push_exp(v, er, cyc + 16);
        @(negedge clk);
        bus.start = 1'b0;
        set_digits(4'd7, 4'd3, 4'd6, 4'd2);
    endtask

    // Wait for all queued results, bounded.
    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 80) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int c;
        bus.start = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);

        repeat (2) @(negedge clk);
        check("rst_binary_out", int'(bus.binary_out), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_err", int'(bus.err), 0);

        // Start accepted on the first edge after reset release.
        n_rst = 1'b1;
        bus.start = 1'b1;
        push_exp(0, 1'b0, cyc + 16);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);

        go(4'd9, 4'd9, 4'd9, 4'd9, 9999, 1'b0);
        go(4'd1, 4'd2, 4'd3, 4'd4, 1234, 1'b0);
        go(4'd0, 4'd0, 4'd0, 4'd1, 1, 1'b0);
        go(4'd5, 4'd0, 4'd0, 4'd0, 5000, 1'b0);
        go(4'd0, 4'd0, 4'd9, 4'd9, 99, 1'b0);
        go(4'd0, 4'd9, 4'd8, 4'd7, 987, 1'b0);
        drain();
        repeat (5) @(negedge clk);
        check("hold_value", int'(bus.binary_out), 987);
        check("idle_busy", int'(bus.busy), 0);

        // Second start mid-conversion is ignored.
        go(4'd1, 4'd2, 4'd3, 4'd4, 1234, 1'b0);
        repeat (4) @(negedge clk);
        set_digits(4'd9, 4'd9, 4'd9, 4'd9);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // Reset mid-conversion aborts it.
        go(4'd9, 4'd9, 4'd9, 4'd9, 9999, 1'b0);
        repeat (6) @(negedge clk);
        n_rst = 1'b0;
        q.delete();
        #1;
        check("abort_binary_out", int'(bus.binary_out), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        go(4'd0, 4'd0, 4'd5, 4'd7, 57, 1'b0);
        drain();

        // Start held high: back-to-back every 16 cycles.
        @(negedge clk);
        c = cyc;
        set_digits(4'd0, 4'd8, 4'd0, 4'd0);
        bus.start = 1'b1;
        push_exp(800, 1'b0, c + 16);
        push_exp(800, 1'b0, c + 32);
        push_exp(800, 1'b0, c + 48);
        repeat (40) @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        check("no_extra_busy", int'(bus.busy), 0);

`ifdef BCD_DIGIT_CHECK_EN
        go(4'd0, 4'd0, 4'hA, 4'd0, 0, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        check("err_hold", int'(bus.err), 1);
        go(4'd0, 4'd0, 4'd1, 4'd0, 10, 1'b0);
        drain();
        check("err_cleared", int'(bus.err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
